random_coord: RTL and testbench
===============================

# random_coord

Converts the free-running 8-bit pseudo-random byte stream from the noise-seeded LFSR into uniformly distributed on-screen pixel coordinates (x in 0..H_MAX-1, y in 0..V_MAX-1). It uses rejection sampling over disjoint LFSR bytes. It sits directly downstream of the LFSR, and its outputs go to the sprite/pixel placement logic through a valid/ready handshake.

## Interface
- H_MAX, 640: exclusive upper bound for x.
- V_MAX, 480: exclusive upper bound for y.
- STRIDE, 8: cycles between consumed bytes, so consumed bytes share no LFSR bits. Legal range 1..255.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- random  in  8  LFSR output; changes every cycle.
- ready  in  1  consumer accepts the coordinate when `ready` and `valid` are both high.
- valid  out  1  x/y hold an accepted coordinate.
- x  out  10  horizontal coordinate.
- y  out  9  vertical coordinate.
- reject_cnt  out  8  saturating count of rejected candidates since reset.

## Operation
- States:
  - X_LO: take a sample into xbuf[7:0].
  - X_HI: take a sample; the candidate is {random[1:0], xbuf}.
  - Y_LO: take a sample into ybuf[7:0].
  - Y_HI: take a sample; the candidate is {random[0], ybuf}.
  - HOLD: valid=1.
- Sample tick: stride_cnt counts 0..STRIDE-1 in every state except HOLD. A sample is taken on the edge where stride_cnt==STRIDE-1, and stride_cnt then wraps to 0. In HOLD, stride_cnt is held at 0.
- Transitions (on sample tick only; non-tick cycles stay in the current state):
  - X_LO to X_HI.
  - X_HI: candidate < H_MAX, latch x and go to Y_LO; otherwise go to X_LO and count a reject.
  - Y_LO to Y_HI.
  - Y_HI: candidate < V_MAX, latch y and go to HOLD; otherwise go to Y_LO and count a reject. An accepted x is kept and is not redrawn.
  - HOLD: on valid&&ready, go to X_LO with valid=0 the next cycle.
- Unused upper bits (random[7:2] in X_HI, random[7:1] in Y_HI) are ignored.
- reject_cnt increments by 1 per rejection and saturates at 255. It is cleared only by rst.
- Width rules:
  - Comparisons are unsigned at 10 bits (x) and 9 bits (y).
  - H_MAX ≤ 1024 and V_MAX ≤ 512.
- x and y change only when latched in X_HI/Y_HI. While valid=1 they are stable; the previous y persists until the new y is latched.
- Reset (any state, including HOLD with ready high): state=X_LO, stride_cnt=0, valid=0, x=0, y=0, reject_cnt=0, xbuf=0, ybuf=0. Reset wins over every other event.

## Timing
- First sample: on the STRIDE-th rising edge after the cycle in which rst was sampled low.
- Minimum latency: 4·STRIDE edges from reset release or handshake to valid=1. Each rejection adds 2·STRIDE.
- valid is registered. The handshake completes on the edge where valid&&ready is sampled, and valid is low the following cycle.
- If ready is high on the edge valid rises, the coordinate is consumed one cycle later, not in the same cycle.
- Outputs are registered. There is no combinational path from random or ready to any output.

## Structure
- Shared header vga_params.vh holds:
  - H_VISIBLE=640 and V_VISIBLE=480, used as the H_MAX/V_MAX defaults.
  - X_W=10 and Y_W=9.
  - State encodings as localparams.
- The timing generator uses the same header.
- No sub-module. The LFSR (Random) is instantiated beside this block at the parent level, not inside it.
- Expected size is about 150–200 lines: FSM, stride counter, byte buffers and the saturating counter.

## Test plan
All scenarios use STRIDE=1 with the bench driving `random` directly.
- Basic: bytes 0x10,0x01,0x20,0x00 after reset → valid=1 after the 4th edge, x=272, y=32, reject_cnt=0.
- x boundary: 0x80,0x02 → x candidate 640 rejected, reject_cnt=1. Then 0x7F,0x02,0x00,0x00 → x=639, y=0.
- y boundary: x bytes 0x00,0x00, then 0xE0,0x01 → y rejected, reject_cnt=1, x stays 0. Then 0xDF,0x01 → y=479.
- Handshake: hold ready=0 for 10 cycles → valid, x and y stable. Raise ready → valid=0 next cycle, and the next coordinate appears 4 edges later.
- Saturation and stride:
  - 300 consecutive rejecting x pairs (0xFF,0xFF) → reject_cnt=255.
  - STRIDE=8 with random changing every cycle → only the bytes on every 8th edge are used, and the first valid appears at edge 32.
- Reset mid-operation: assert rst while in Y_HI and again while in HOLD with ready=1 → all outputs are 0 the next cycle, and the sequence restarts from X_LO.

Source files
------------

// File: rtl/random_coord_pkg.sv
// random_coord_pkg
//   Shared screen geometry, coordinate widths and FSM state encoding for the
//   random coordinate generator. The same values are used by the timing
//   generator, so the visible area is defined in exactly one place.
package random_coord_pkg;

  // Visible raster size; default bounds for generated coordinates.
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  // Coordinate widths.
  localparam int unsigned X_W = 10;
  localparam int unsigned Y_W = 9;

  // Rejection-sampling FSM states.
  typedef enum logic [2:0] {
    ST_X_LO = 3'd0,  // sample low byte of x candidate
    ST_X_HI = 3'd1,  // sample high bits of x candidate, test bound
    ST_Y_LO = 3'd2,  // sample low byte of y candidate
    ST_Y_HI = 3'd3,  // sample high bit of y candidate, test bound
    ST_HOLD = 3'd4   // present coordinate until consumed
  } state_e;

endpackage

// File: rtl/random_coord.sv
// random_coord
//   Turns the free-running 8-bit LFSR byte stream into uniformly distributed
//   pixel coordinates by rejection sampling. Only one byte every STRIDE cycles
//   is consumed, so successive consumed bytes share no LFSR bits.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   random     in   [7:0] LFSR output, changes every cycle
//   ready      in   consumer accepts when ready && valid
//   valid      out  x/y hold an accepted coordinate
//   x          out  [X_W-1:0] horizontal coordinate, 0..H_MAX-1
//   y          out  [Y_W-1:0] vertical coordinate, 0..V_MAX-1
//   reject_cnt out  [7:0] saturating count of rejected candidates
module random_coord
  import random_coord_pkg::*;
#(
  parameter int unsigned H_MAX  = H_VISIBLE,  // exclusive bound, <= 1024
  parameter int unsigned V_MAX  = V_VISIBLE,  // exclusive bound, <= 512
  parameter int unsigned STRIDE = 8           // 1..255
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     random,
  input  logic           ready,
  output logic           valid,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [7:0]     reject_cnt
);

  localparam logic [7:0] STRIDE_LAST = 8'(STRIDE - 1);

  state_e         state_q, state_d;
  logic [7:0]     stride_q, stride_d;
  logic [7:0]     xbuf_q, xbuf_d;
  logic [7:0]     ybuf_q, ybuf_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           valid_q, valid_d;
  logic [7:0]     rej_q, rej_d;

  logic           tick;
  logic           rej_inc;
  logic [X_W-1:0] x_cand;
  logic [Y_W-1:0] y_cand;

  // Candidates combine the buffered low byte with the low bits of the current
  // sample; the remaining high bits of the current sample are discarded.
  assign x_cand = {random[1:0], xbuf_q};
  assign y_cand = {random[0], ybuf_q};

  // The stride counter is parked in HOLD, so no tick can occur there.
  assign tick = (state_q != ST_HOLD) && (stride_q == STRIDE_LAST);

  always_comb begin
    state_d  = state_q;
    stride_d = stride_q;
    xbuf_d   = xbuf_q;
    ybuf_d   = ybuf_q;
    x_d      = x_q;
    y_d      = y_q;
    valid_d  = valid_q;
    rej_d    = rej_q;
    rej_inc  = 1'b0;

    if (state_q == ST_HOLD) begin
      stride_d = 8'd0;
    end else if (tick) begin
      stride_d = 8'd0;
    end else begin
      stride_d = 8'(stride_q + 8'd1);
    end

    case (state_q)
      ST_X_LO: begin
        if (tick) begin
          xbuf_d  = random;
          state_d = ST_X_HI;
        end
      end
      ST_X_HI: begin
        if (tick) begin
          // Zero-extended compare so H_MAX=1024 accepts every candidate.
          if (32'(x_cand) < H_MAX) begin
            x_d     = x_cand;
            state_d = ST_Y_LO;
          end else begin
            rej_inc = 1'b1;
            state_d = ST_X_LO;
          end
        end
      end
      ST_Y_LO: begin
        if (tick) begin
          ybuf_d  = random;
          state_d = ST_Y_HI;
        end
      end
      ST_Y_HI: begin
        if (tick) begin
          // A y rejection redraws only y; the accepted x is kept.
          if (32'(y_cand) < V_MAX) begin
            y_d     = y_cand;
            valid_d = 1'b1;
            state_d = ST_HOLD;
          end else begin
            rej_inc = 1'b1;
            state_d = ST_Y_LO;
          end
        end
      end
      ST_HOLD: begin
        if (valid_q && ready) begin
          valid_d = 1'b0;
          state_d = ST_X_LO;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_X_LO;
      end
    endcase

    if (rej_inc && (rej_q != 8'hFF)) begin
      rej_d = 8'(rej_q + 8'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_X_LO;
      stride_q <= 8'd0;
      xbuf_q   <= 8'd0;
      ybuf_q   <= 8'd0;
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      rej_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      stride_q <= stride_d;
      xbuf_q   <= xbuf_d;
      ybuf_q   <= ybuf_d;
      x_q      <= x_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      rej_q    <= rej_d;
    end
  end

  assign valid      = valid_q;
  assign x          = x_q;
  assign y          = y_q;
  assign reject_cnt = rej_q;

endmodule

// File: tb/tb_random_coord.sv
// tb_random_coord
//   Directed, table-driven bench for random_coord. One instance runs with
//   STRIDE=1 for byte-exact scenarios, a second with STRIDE=8 checks that only
//   every 8th byte is consumed.
module tb_random_coord;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] random = 8'd0;
  logic       ready1 = 1'b0;
  logic       ready8 = 1'b0;

  logic       valid1, valid8;
  logic [9:0] x1, x8;
  logic [8:0] y1, y8;
  logic [7:0] rej1, rej8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  random_coord #(.H_MAX(640), .V_MAX(480), .STRIDE(1)) dut1 (
    .clk(clk), .rst(rst), .random(random), .ready(ready1),
    .valid(valid1), .x(x1), .y(y1), .reject_cnt(rej1)
  );

  random_coord #(.H_MAX(640), .V_MAX(480), .STRIDE(8)) dut8 (
    .clk(clk), .rst(rst), .random(random), .ready(ready8),
    .valid(valid8), .x(x8), .y(y8), .reject_cnt(rej8)
  );

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    logic [9:0] ex;
    logic [8:0] ey;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one byte and advance one rising edge; outputs are sampled 1 time
  // unit after the edge.
  task automatic step(input logic [7:0] b);
    random = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(valid1), 32'd0);
    chk({tag, "_x"}, 32'(x1), 32'd0);
    chk({tag, "_y"}, 32'(y1), 32'd0);
    chk({tag, "_rej"}, 32'(rej1), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ready1 = 1'b0;
    step(8'h00);
    rst = 1'b0;
  endtask

  // Consume the current coordinate on dut1.
  task automatic handshake();
    ready1 = 1'b1;
    step(8'h00);
    ready1 = 1'b0;
    chk("hs_valid_low", 32'(valid1), 32'd0);
  endtask

  initial begin
    vecs[0] = '{b0: 8'h10, b1: 8'h01, b2: 8'h20, b3: 8'h00, ex: 10'd272, ey: 9'd32};
    vecs[1] = '{b0: 8'h7F, b1: 8'h02, b2: 8'h00, b3: 8'h00, ex: 10'd639, ey: 9'd0};
    vecs[2] = '{b0: 8'h00, b1: 8'h00, b2: 8'hDF, b3: 8'h01, ex: 10'd0,   ey: 9'd479};
    vecs[3] = '{b0: 8'hFF, b1: 8'hFC, b2: 8'hFF, b3: 8'hFE, ex: 10'd255, ey: 9'd255};
    vecs[4] = '{b0: 8'h34, b1: 8'hF9, b2: 8'h2A, b3: 8'h01, ex: 10'd308, ey: 9'd298};
    vecs[5] = '{b0: 8'h00, b1: 8'h01, b2: 8'h01, b3: 8'h00, ex: 10'd256, ey: 9'd1};

    step(8'h00);
    step(8'h00);

    // Reset state
    do_reset();
    chk_zero("reset");

    // Table-driven accepted coordinates with handshake between them
    for (int i = 0; i < 6; i++) begin
      step(vecs[i].b0);
      step(vecs[i].b1);
      step(vecs[i].b2);
      chk($sformatf("v%0d_notyet", i), 32'(valid1), 32'd0);
      step(vecs[i].b3);
      chk($sformatf("v%0d_valid", i), 32'(valid1), 32'd1);
      chk($sformatf("v%0d_x", i), 32'(x1), 32'(vecs[i].ex));
      chk($sformatf("v%0d_y", i), 32'(y1), 32'(vecs[i].ey));
      chk($sformatf("v%0d_rej", i), 32'(rej1), 32'd0);
      $display("vector %0d: x=%0d y=%0d valid=%0d", i, x1, y1, valid1);
      handshake();
    end

    // x boundary: 640 rejected, 639 accepted
    do_reset();
    step(8'h80);
    step(8'h02);
    chk("xb_rej", 32'(rej1), 32'd1);
    chk("xb_x_unlatched", 32'(x1), 32'd0);
    step(8'h7F); step(8'h02); step(8'h00); step(8'h00);
    chk("xb_valid", 32'(valid1), 32'd1);
    chk("xb_x", 32'(x1), 32'd639);
    chk("xb_y", 32'(y1), 32'd0);
    $display("x boundary: x=%0d y=%0d rej=%0d", x1, y1, rej1);

    // y boundary: 480 rejected, x kept, 479 accepted
    do_reset();
    step(8'h05); step(8'h01);
    chk("yb_x_latched", 32'(x1), 32'd261);
    step(8'hE0); step(8'h01);
    chk("yb_rej", 32'(rej1), 32'd1);
    chk("yb_valid_low", 32'(valid1), 32'd0);
    step(8'hDF); step(8'h01);
    chk("yb_valid", 32'(valid1), 32'd1);
    chk("yb_x_kept", 32'(x1), 32'd261);
    chk("yb_y", 32'(y1), 32'd479);
    $display("y boundary: x=%0d y=%0d rej=%0d", x1, y1, rej1);

    // Handshake: stable while ready low, consumed after ready high
    for (int i = 0; i < 10; i++) begin
      step(8'(i * 37 + 3));
      chk("hold_valid", 32'(valid1), 32'd1);
      chk("hold_x", 32'(x1), 32'd261);
      chk("hold_y", 32'(y1), 32'd479);
    end
    handshake();
    step(8'h10); step(8'h01);
    chk("y_persists", 32'(y1), 32'd479);
    chk("new_x", 32'(x1), 32'd272);
    // ready already high when valid rises: consumed one cycle later
    ready1 = 1'b1;
    step(8'h20);
    chk("rdy_early_notyet", 32'(valid1), 32'd0);
    step(8'h00);
    chk("rdy_early_valid", 32'(valid1), 32'd1);
    chk("rdy_early_y", 32'(y1), 32'd32);
    step(8'h00);
    chk("rdy_early_consumed", 32'(valid1), 32'd0);
    ready1 = 1'b0;
    $display("handshake: sequence done");

    // Saturation of reject counter
    do_reset();
    for (int i = 0; i < 254; i++) begin
      step(8'hFF); step(8'hFF);
    end
    chk("sat_254", 32'(rej1), 32'd254);
    step(8'hFF); step(8'hFF);
    chk("sat_255", 32'(rej1), 32'd255);
    for (int i = 0; i < 45; i++) begin
      step(8'hFF); step(8'hFF);
    end
    chk("sat_300", 32'(rej1), 32'd255);
    chk("sat_valid", 32'(valid1), 32'd0);
    $display("saturation: rej=%0d", rej1);

    // STRIDE=8: only bytes on edges 8,16,24,32 are used
    begin
      logic [7:0] sel [4];
      sel[0] = 8'h10; sel[1] = 8'h01; sel[2] = 8'h20; sel[3] = 8'h00;
      do_reset();
      for (int k = 1; k <= 32; k++) begin
        step(((k % 8) == 0) ? sel[k / 8 - 1] : 8'hFF);
        if (k == 31) chk("s8_notyet", 32'(valid8), 32'd0);
      end
      chk("s8_valid", 32'(valid8), 32'd1);
      chk("s8_x", 32'(x8), 32'd272);
      chk("s8_y", 32'(y8), 32'd32);
      chk("s8_rej", 32'(rej8), 32'd0);
      $display("stride 8: x=%0d y=%0d valid=%0d", x8, y8, valid8);
    end

    // Reset while in Y_HI
    do_reset();
    step(8'h10); step(8'h01); step(8'h20);
    rst = 1'b1;
    step(8'h00);
    rst = 1'b0;
    chk_zero("rst_yhi");
    step(8'h7F); step(8'h02); step(8'h00); step(8'h00);
    chk("rst_yhi_restart_valid", 32'(valid1), 32'd1);
    chk("rst_yhi_restart_x", 32'(x1), 32'd639);
    $display("reset in Y_HI: restart x=%0d y=%0d", x1, y1);

    // Reset while in HOLD with ready high
    ready1 = 1'b1;
    rst = 1'b1;
    step(8'h00);
    rst = 1'b0;
    ready1 = 1'b0;
    chk_zero("rst_hold");
    step(8'h10); step(8'h01); step(8'h20); step(8'h00);
    chk("rst_hold_restart_valid", 32'(valid1), 32'd1);
    chk("rst_hold_restart_x", 32'(x1), 32'd272);
    chk("rst_hold_restart_y", 32'(y1), 32'd32);
    $display("reset in HOLD: restart x=%0d y=%0d", x1, y1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
